hazard_control: RTL and testbench
=================================

# hazard_control

Parametrised pipeline hazard/stall controller between the fetch/decode front end and the ROB-based back end. It generalises the single-instruction stall logic to a DISPATCH_W-wide dispatch, and adds the following behaviour:
- a registered ROB occupancy counter with per-cycle dispatch and commit counts;
- a multi-cycle flush-recovery window;
- a serialise (fence) drain mode that holds dispatch until the ROB is empty.

## Interface
Parameters:
- ROB_DEPTH, 16: ROB entries; ≥2.
- DISPATCH_W, 2: max instructions dispatched per cycle; 1..ROB_DEPTH.
- COMMIT_W, 2: max instructions committed per cycle; 1..ROB_DEPTH.
- FLUSH_CYCLES, 2: cycles spent in FLUSH after a flush pulse; ≥1.
- Derived widths: CW = $clog2(ROB_DEPTH+1), DW = $clog2(DISPATCH_W+1), KW = $clog2(COMMIT_W+1).

Ports:
- clk, in, 1: single clock, rising edge.
- reset, in, 1: asynchronous, active-high.
- busy, in, 1: instruction cache busy.
- overwrite_pc, in, 1: PC redirect in progress at fetch.
- instruction, in, 1: fetch bundle valid.
- dispatch_req, in, DW: instructions decode wants to dispatch this cycle (0..DISPATCH_W).
- commit_cnt, in, KW: instructions retired this cycle (0..COMMIT_W).
- flush, in, 1: mispredict/exception flush pulse.
- serialize, in, 1: fence/serialising instruction at dispatch.
- backend_busy, in, 1: multi-cycle execution unit occupied.
- frontend_stall, out, 1: hold fetch/decode.
- backend_stall, out, 1: hold issue.
- dispatch_grant, out, DW: instructions accepted into the ROB this cycle.
- rob_count, out, CW: registered ROB occupancy.
- rob_full, out, 1: rob_count == ROB_DEPTH.
- rob_empty, out, 1: rob_count == 0.
- flushing, out, 1: state is FLUSH.
- count_err, out, 1: sticky underflow error.

## Operation
State machine, with states RUN, FLUSH and DRAIN:
- **Any state:** flush=1 → FLUSH, flush_ctr ← FLUSH_CYCLES-1. flush has priority over serialize and every other transition.
- **FLUSH:** flush_ctr decrements each cycle. At 0 the state moves to RUN the following edge; if serialize is also high on that exit cycle, it moves to DRAIN instead. A new flush reloads the counter.
- **RUN:** serialize=1 with dispatch_grant≠0 → DRAIN. The serialising bundle itself is dispatched.
- **DRAIN:** rob_empty=1 → RUN.

Combinational outputs:
- free = ROB_DEPTH − rob_count. Commits in the same cycle are deliberately not credited.
- frontend_stall = reset | (state≠RUN) | busy | overwrite_pc | !instruction | (dispatch_req > free).
- dispatch_grant = frontend_stall ? 0 : dispatch_req. Dispatch is all-or-nothing: a bundle is never split.
- backend_stall = reset | backend_busy | (state==FLUSH).
- rob_full, rob_empty and flushing are decoded from registered state only.

ROB occupancy counter:
- On a flush cycle: rob_count ← 0. dispatch_grant and commit_cnt in that cycle are discarded.
- Otherwise: rob_count ← rob_count + dispatch_grant − commit_cnt, computed at CW+1 bits.
- If commit_cnt > rob_count + dispatch_grant: rob_count ← 0 and count_err ← 1 (sticky until reset).
- Overflow cannot occur, because grant ≤ free.
- commit_cnt is honoured in every state except on a flush cycle.

## Timing
- Reset (asynchronous, immediate):
  - state = RUN, rob_count = 0, flush_ctr = 0, count_err = 0.
  - rob_empty = 1, rob_full = 0, flushing = 0.
  - frontend_stall = 1, backend_stall = 1, dispatch_grant = 0.
- frontend_stall, backend_stall and dispatch_grant are same-cycle combinational paths from the inputs.
- rob_count, state and count_err update on the next rising edge.
- Flush with FLUSH_CYCLES=N:
  - flush is high in cycle t; flushing is high in cycles t+1..t+N.
  - First possible grant is in cycle t+N+1.
- Full-ROB boundary:
  - rob_count = ROB_DEPTH−1 with dispatch_req = 2 → stall, grant 0.
  - dispatch_req = 1 → grant 1, and rob_full is asserted the next cycle.
- DRAIN exit: rob_empty is seen in cycle t → RUN in cycle t+1, and dispatch is possible in t+1.
- Reset asserted mid-FLUSH or mid-DRAIN: state returns to RUN immediately.

## Test plan
- **Reset/basic:** release reset; instruction=1, busy=0, dispatch_req=2, commit_cnt=0 for 8 cycles.
  - Grant 2 per cycle; rob_count 0,2,4,…,16.
  - In the 9th cycle: frontend_stall=1, rob_full=1, grant 0.
- **Partial fit:** rob_count=15, dispatch_req=2 → grant 0. Then dispatch_req=1 → grant 1, rob_count=16.
- **Simultaneous:** rob_count=10, grant 2, commit_cnt=2 in the same cycle → rob_count stays 10. Then commit_cnt=2, grant 0 → 8.
- **Flush:** rob_count=12, flush pulse together with dispatch_req=2 and commit_cnt=1.
  - Next cycle rob_count=0 and flushing=1 for exactly 2 cycles; backend_stall=1 throughout.
  - First grant occurs 3 cycles after the pulse.
- **Serialise:** rob_count=4, serialize with grant 2 → DRAIN, frontend_stall=1.
  - commit_cnt=2 for 3 cycles brings rob_count 6→4→2→0.
  - RUN the cycle after rob_empty=1.
  - A flush injected during DRAIN goes to FLUSH instead.
- **Underflow:** rob_count=1, commit_cnt=2, grant 0 → rob_count=0, count_err=1. count_err holds until reset.

Source files
------------

// File: rtl/hazard_control_if.sv
// Hazard controller bundle: front-end/back-end requests in, stall/grant/ROB status out.
// master = pipeline side (drives requests), slave = hazard_control.
interface hazard_control_if #(
    parameter int ROB_DEPTH  = 16,
    parameter int DISPATCH_W = 2,
    parameter int COMMIT_W   = 2
);
    localparam int CW = $clog2(ROB_DEPTH + 1);
    localparam int DW = $clog2(DISPATCH_W + 1);
    localparam int KW = $clog2(COMMIT_W + 1);

    logic          busy;
    logic          overwrite_pc;
    logic          instruction;
    logic [DW-1:0] dispatch_req;
    logic [KW-1:0] commit_cnt;
    logic          flush;
    logic          serialize;
    logic          backend_busy;

    logic          frontend_stall;
    logic          backend_stall;
    logic [DW-1:0] dispatch_grant;
    logic [CW-1:0] rob_count;
    logic          rob_full;
    logic          rob_empty;
    logic          flushing;
    logic          count_err;

    modport master (
        output busy, overwrite_pc, instruction, dispatch_req,
        output commit_cnt, flush, serialize, backend_busy,
        input  frontend_stall, backend_stall, dispatch_grant,
        input  rob_count, rob_full, rob_empty, flushing, count_err
    );

    modport slave (
        input  busy, overwrite_pc, instruction, dispatch_req,
        input  commit_cnt, flush, serialize, backend_busy,
        output frontend_stall, backend_stall, dispatch_grant,
        output rob_count, rob_full, rob_empty, flushing, count_err
    );
endinterface

// File: rtl/hazard_control.sv
// Pipeline hazard/stall controller: wide dispatch grant, ROB occupancy, flush window, fence drain.
// Ports: clk, reset (async, active-high), bus (hazard_control_if.slave).
module hazard_control #(
    parameter int ROB_DEPTH    = 16,
    parameter int DISPATCH_W   = 2,
    parameter int COMMIT_W     = 2,
    parameter int FLUSH_CYCLES = 2
) (
    input  logic             clk,
    input  logic             reset,
    hazard_control_if.slave  bus
);
    localparam int CW  = $clog2(ROB_DEPTH + 1);
    localparam int CW1 = CW + 1;
    localparam int DW  = $clog2(DISPATCH_W + 1);
    localparam int KW  = $clog2(COMMIT_W + 1);
    localparam int FCW = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;

    localparam logic [CW:0]    DEPTH_L = CW1'(ROB_DEPTH);
    localparam logic [FCW-1:0] FLOAD   = FCW'(FLUSH_CYCLES - 1);

    typedef enum logic [1:0] {
        RUN   = 2'd0,
        FLUSH = 2'd1,
        DRAIN = 2'd2
    } state_e;

    state_e         state_q, state_d;
    logic [FCW-1:0] fctr_q, fctr_d;
    logic [CW-1:0]  cnt_q, cnt_d;
    logic           err_q, err_d;

    logic [DW-1:0]  grant;
    logic [KW-1:0]  commit_w;
    logic [CW:0]    free_w;
    logic [CW:0]    req_w;
    logic [CW:0]    sum_w;
    logic [CW:0]    com_w;
    logic           fe_stall;
    logic           be_stall;
    logic           empty_w;

    assign commit_w = bus.commit_cnt;
    assign empty_w  = (cnt_q == '0);

    // Same-cycle commits are not credited, keeping the grant path short.
    assign free_w = DEPTH_L - CW1'(cnt_q);
    assign req_w  = CW1'(bus.dispatch_req);

    // State register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= RUN;
            fctr_q  <= '0;
        end else begin
            state_q <= state_d;
            fctr_q  <= fctr_d;
        end
    end

    // Next-state logic; flush overrides every other transition
    always_comb begin
        state_d = state_q;
        fctr_d  = fctr_q;
        if (bus.flush) begin
            state_d = FLUSH;
            fctr_d  = FLOAD;
        end else begin
            unique case (state_q)
                RUN: begin
                    if (bus.serialize && (grant != '0))
                        state_d = DRAIN;
                end
                FLUSH: begin
                    if (fctr_q == '0)
                        state_d = bus.serialize ? DRAIN : RUN;
                    else
                        fctr_d = fctr_q - 1'b1;
                end
                DRAIN: begin
                    if (empty_w)
                        state_d = RUN;
                end
                default: state_d = RUN;
            endcase
        end
    end

    // Output logic
    always_comb begin
        fe_stall = reset
                 | (state_q != RUN)
                 | bus.busy
                 | bus.overwrite_pc
                 | ~bus.instruction
                 | (req_w > free_w);
        // Bundles are granted whole or not at all.
        grant    = fe_stall ? '0 : bus.dispatch_req;
        be_stall = reset | bus.backend_busy | (state_q == FLUSH);
    end

    // Occupancy next-state; underflow is checked at full width
    always_comb begin
        sum_w = CW1'(cnt_q) + CW1'(grant);
        com_w = CW1'(commit_w);
        cnt_d = cnt_q;
        err_d = err_q;
        if (bus.flush) begin
            cnt_d = '0;
        end else if (com_w > sum_w) begin
            cnt_d = '0;
            err_d = 1'b1;
        end else begin
            // grant never exceeds free, so the sum fits in CW bits
            cnt_d = cnt_q + CW'(grant) - CW'(commit_w);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q <= '0;
            err_q <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            err_q <= err_d;
        end
    end

    assign bus.frontend_stall = fe_stall;
    assign bus.backend_stall  = be_stall;
    assign bus.dispatch_grant = grant;
    assign bus.rob_count      = cnt_q;
    assign bus.rob_full       = (CW1'(cnt_q) == DEPTH_L);
    assign bus.rob_empty      = empty_w;
    assign bus.flushing       = (state_q == FLUSH);
    assign bus.count_err      = err_q;
endmodule

// File: tb/tb_hazard_control.sv
// Self-checking bench for hazard_control: vector table, directed corner sequences,
// randomized traffic against an occupancy/mode reference model.
module tb_hazard_control;
    localparam int DEPTH = 16;
    localparam int DWN   = 2;
    localparam int CWN   = 2;
    localparam int FC    = 2;
    localparam int DW    = $clog2(DWN + 1);
    localparam int KW    = $clog2(CWN + 1);

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    hazard_control_if #(
        .ROB_DEPTH(DEPTH), .DISPATCH_W(DWN), .COMMIT_W(CWN)
    ) hif ();

    hazard_control #(
        .ROB_DEPTH(DEPTH), .DISPATCH_W(DWN),
        .COMMIT_W(CWN), .FLUSH_CYCLES(FC)
    ) dut (
        .clk(clk),
        .reset(reset),
        .bus(hif)
    );

    int checks = 0;
    int errors = 0;

    typedef struct {
        int req;
        int commit;
        int exp_fs;
        int exp_grant;
        int exp_count;
        int exp_full;
        int exp_empty;
    } vec_t;

    vec_t tbl[9];

    // reference model state
    int m_occ, m_fl, m_err;
    bit m_dr;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d want %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic drive(input int req, input int commit, input int fl,
                         input int ser, input int bsy = 0, input int ovr = 0,
                         input int ins = 1, input int bb = 0);
        hif.dispatch_req = DW'(req);
        hif.commit_cnt   = KW'(commit);
        hif.flush        = fl[0];
        hif.serialize    = ser[0];
        hif.busy         = bsy[0];
        hif.overwrite_pc = ovr[0];
        hif.instruction  = ins[0];
        hif.backend_busy = bb[0];
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        drive(0, 0, 0, 0);
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
        m_occ = 0;
        m_fl  = 0;
        m_err = 0;
        m_dr  = 1'b0;
    endtask

    task automatic rand_cycle();
        int req, c, fl, ser, bsy, ovr, ins, bb, g, t;
        bit fs;
        req = $urandom_range(0, DWN);
        c   = $urandom_range(0, CWN);
        if (c > m_occ && $urandom_range(0, 39) != 0) c = m_occ;
        fl  = ($urandom_range(0, 19) == 0) ? 1 : 0;
        ser = ($urandom_range(0, 9) == 0) ? 1 : 0;
        bsy = ($urandom_range(0, 9) == 0) ? 1 : 0;
        ovr = ($urandom_range(0, 9) == 0) ? 1 : 0;
        ins = ($urandom_range(0, 6) == 0) ? 0 : 1;
        bb  = ($urandom_range(0, 4) == 0) ? 1 : 0;
        drive(req, c, fl, ser, bsy, ovr, ins, bb);
        @(negedge clk);
        fs = (m_fl > 0) || m_dr || bsy != 0 || ovr != 0 || ins == 0
             || (req > DEPTH - m_occ);
        g = fs ? 0 : req;
        chk("r_fs", hif.frontend_stall, fs);
        chk("r_grant", hif.dispatch_grant, g);
        chk("r_bs", hif.backend_stall, (bb != 0) || (m_fl > 0));
        chk("r_count", hif.rob_count, m_occ);
        chk("r_full", hif.rob_full, m_occ == DEPTH);
        chk("r_empty", hif.rob_empty, m_occ == 0);
        chk("r_flushing", hif.flushing, m_fl > 0);
        chk("r_err", hif.count_err, m_err);
        if (fl != 0) begin
            m_occ = 0;
            m_fl  = FC;
            m_dr  = 1'b0;
        end else begin
            if (m_fl > 0) begin
                m_fl--;
                if (m_fl == 0 && ser != 0) m_dr = 1'b1;
            end else if (m_dr) begin
                if (m_occ == 0) m_dr = 1'b0;
            end else if (ser != 0 && g > 0) begin
                m_dr = 1'b1;
            end
            t = m_occ + g - c;
            if (t < 0) begin
                m_occ = 0;
                m_err = 1;
            end else begin
                m_occ = t;
            end
        end
        tick();
    endtask

    initial begin
        for (int i = 0; i < 8; i++)
            tbl[i] = '{2, 0, 0, 2, 2 * i, 0, (i == 0) ? 1 : 0};
        tbl[8] = '{2, 0, 1, 0, 16, 1, 0};

        reset = 1'b1;
        drive(2, 0, 0, 0);
        #1;
        chk("rst_fs", hif.frontend_stall, 1);
        chk("rst_bs", hif.backend_stall, 1);
        chk("rst_grant", hif.dispatch_grant, 0);
        chk("rst_empty", hif.rob_empty, 1);
        chk("rst_full", hif.rob_full, 0);
        chk("rst_flushing", hif.flushing, 0);
        chk("rst_err", hif.count_err, 0);
        chk("rst_count", hif.rob_count, 0);
        tick();
        tick();
        reset = 1'b0;

        // fill the ROB two at a time
        for (int i = 0; i < 9; i++) begin
            drive(tbl[i].req, tbl[i].commit, 0, 0);
            @(negedge clk);
            chk("tbl_fs", hif.frontend_stall, tbl[i].exp_fs);
            chk("tbl_grant", hif.dispatch_grant, tbl[i].exp_grant);
            chk("tbl_count", hif.rob_count, tbl[i].exp_count);
            chk("tbl_full", hif.rob_full, tbl[i].exp_full);
            chk("tbl_empty", hif.rob_empty, tbl[i].exp_empty);
            tick();
        end

        // partial fit at ROB_DEPTH-1
        drive(0, 1, 0, 0);
        @(negedge clk);
        chk("pf_count16", hif.rob_count, 16);
        tick();
        drive(2, 0, 0, 0);
        @(negedge clk);
        chk("pf_grant0", hif.dispatch_grant, 0);
        chk("pf_fs", hif.frontend_stall, 1);
        chk("pf_count15", hif.rob_count, 15);
        tick();
        drive(1, 0, 0, 0);
        @(negedge clk);
        chk("pf_grant1", hif.dispatch_grant, 1);
        tick();
        drive(0, 0, 0, 0);
        @(negedge clk);
        chk("pf_full_count", hif.rob_count, 16);
        chk("pf_full", hif.rob_full, 1);
        tick();

        // simultaneous dispatch and commit
        for (int k = 0; k < 3; k++) begin
            drive(0, 2, 0, 0);
            @(negedge clk);
            chk("sim_drain", hif.rob_count, 16 - 2 * k);
            tick();
        end
        drive(2, 2, 0, 0);
        @(negedge clk);
        chk("sim_count10", hif.rob_count, 10);
        chk("sim_grant2", hif.dispatch_grant, 2);
        tick();
        drive(0, 2, 0, 0);
        @(negedge clk);
        chk("sim_hold10", hif.rob_count, 10);
        tick();
        drive(0, 0, 0, 0);
        @(negedge clk);
        chk("sim_count8", hif.rob_count, 8);
        tick();

        // flush window
        drive(2, 0, 0, 0);
        tick();
        tick();
        drive(2, 1, 1, 0);
        @(negedge clk);
        chk("fl_count12", hif.rob_count, 12);
        chk("fl_bs_pulse", hif.backend_stall, 0);
        tick();
        drive(2, 0, 0, 0);
        for (int k = 1; k <= 3; k++) begin
            @(negedge clk);
            chk("fl_count0", hif.rob_count, 0);
            chk("fl_flushing", hif.flushing, (k <= FC) ? 1 : 0);
            chk("fl_bs", hif.backend_stall, (k <= FC) ? 1 : 0);
            chk("fl_grant", hif.dispatch_grant, (k <= FC) ? 0 : 2);
            tick();
        end
        @(negedge clk);
        chk("fl_count2", hif.rob_count, 2);
        tick();

        // serialise drain
        drive(2, 0, 0, 1);
        @(negedge clk);
        chk("ser_count4", hif.rob_count, 4);
        chk("ser_grant", hif.dispatch_grant, 2);
        tick();
        for (int k = 0; k < 3; k++) begin
            drive(2, 2, 0, 0);
            @(negedge clk);
            chk("dr_count", hif.rob_count, 6 - 2 * k);
            chk("dr_fs", hif.frontend_stall, 1);
            chk("dr_grant", hif.dispatch_grant, 0);
            tick();
        end
        drive(2, 0, 0, 0);
        @(negedge clk);
        chk("dr_empty", hif.rob_empty, 1);
        chk("dr_fs_empty", hif.frontend_stall, 1);
        tick();
        @(negedge clk);
        chk("dr_exit_fs", hif.frontend_stall, 0);
        chk("dr_exit_grant", hif.dispatch_grant, 2);
        tick();

        // flush wins during drain
        drive(1, 0, 0, 1);
        @(negedge clk);
        chk("dr2_grant", hif.dispatch_grant, 1);
        tick();
        drive(0, 0, 1, 0);
        @(negedge clk);
        chk("dr2_fs", hif.frontend_stall, 1);
        chk("dr2_count3", hif.rob_count, 3);
        tick();
        drive(1, 0, 0, 0);
        for (int k = 1; k <= 3; k++) begin
            @(negedge clk);
            chk("dr2_flushing", hif.flushing, (k <= FC) ? 1 : 0);
            chk("dr2_grant_after", hif.dispatch_grant, (k <= FC) ? 0 : 1);
            tick();
        end

        // underflow
        drive(0, 2, 0, 0);
        @(negedge clk);
        chk("uf_count1", hif.rob_count, 1);
        chk("uf_err_before", hif.count_err, 0);
        tick();
        drive(2, 0, 0, 0);
        @(negedge clk);
        chk("uf_count0", hif.rob_count, 0);
        chk("uf_err", hif.count_err, 1);
        tick();
        tick();
        @(negedge clk);
        chk("uf_err_sticky", hif.count_err, 1);
        tick();

        // asynchronous reset in the middle of FLUSH
        drive(0, 0, 1, 0);
        tick();
        drive(0, 0, 0, 0);
        @(negedge clk);
        chk("ar_flushing", hif.flushing, 1);
        reset = 1'b1;
        #1;
        chk("ar_flushing_clr", hif.flushing, 0);
        chk("ar_err_clr", hif.count_err, 0);
        chk("ar_fs", hif.frontend_stall, 1);
        chk("ar_bs", hif.backend_stall, 1);
        tick();
        reset = 1'b0;

        // randomized traffic against the model
        for (int b = 0; b < 4; b++) begin
            do_reset();
            for (int n = 0; n < 600; n++)
                rand_cycle();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
